// File: rtl/freq_check.sv
// rtl/freq_check.sv - half-period measurement and lock/loss-of-signal detector for a divided clock
//
// Measures each half-period of s_in in clk cycles and tracks whether the
// signal stays within HALF_NOM +/- TOL for LOCK_N consecutive half-periods.
//
// Ports:
//   clk        system clock, all logic on posedge
//   rst        asynchronous, active-low reset
//   s_in       divided square wave under test, asynchronous to clk
//   half_len   length of the last completed half-period, in clk cycles
//   level      synchronized s_in level during the half-period in half_len
//   meas_valid one-cycle pulse when half_len and level update
//   locked     high while LOCK_N or more consecutive half-periods were in tolerance
//   timeout    high while no s_in edge has arrived for TIMEOUT cycles
module freq_check #(
    parameter int unsigned HALF_NOM = 500000,
    parameter int unsigned TOL      = 16,
    parameter int unsigned LOCK_N   = 4,
    parameter int unsigned TIMEOUT  = 1000000,
    parameter int unsigned CW       = 20
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_in,
    output logic [CW-1:0] half_len,
    output logic          level,
    output logic          meas_valid,
    output logic          locked,
    output logic          timeout
);

    localparam int unsigned GW = (LOCK_N > 1) ? $clog2(LOCK_N + 1) : 1;
    // Lower bound clamps at zero instead of wrapping when TOL > HALF_NOM.
    localparam int unsigned LO = (HALF_NOM > TOL) ? (HALF_NOM - TOL) : 0;
    localparam int unsigned HI = HALF_NOM + TOL;
    localparam logic [CW-1:0] TO_C   = CW'(TIMEOUT);
    localparam logic [GW-1:0] LOCK_C = GW'(LOCK_N);

    typedef enum logic [1:0] {
        WAIT_EDGE,
        MEASURE,
        LOCK
    } state_t;

    state_t        state_q, state_d;
    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic          prev_q, prev_d;
    logic [1:0]    warm_q, warm_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] half_len_q, half_len_d;
    logic          level_q, level_d;
    logic          meas_valid_q, meas_valid_d;
    logic          locked_q, locked_d;
    logic          timeout_q, timeout_d;
    logic [GW-1:0] good_q, good_d;

    logic          edge_det;
    logic          in_tol;
    logic [GW-1:0] good_inc;

    always_comb begin
        state_d      = state_q;
        sync1_d      = s_in;
        sync2_d      = sync2_q;
        prev_d       = prev_q;
        warm_d       = warm_q;
        cnt_d        = (cnt_q == TO_C) ? TO_C : cnt_q + CW'(1);
        half_len_d   = half_len_q;
        level_d      = level_q;
        meas_valid_d = 1'b0;
        locked_d     = locked_q;
        timeout_d    = timeout_q;
        good_d       = good_q;

        // After reset release the chain is preset from the first sampled
        // value (via sync1, which has had one cycle to settle) so that the
        // release itself never looks like an edge.
        case (warm_q)
            2'd0: begin
                warm_d = 2'd1;
            end
            2'd1: begin
                sync2_d = sync1_q;
                prev_d  = sync1_q;
                warm_d  = 2'd2;
            end
            default: begin
                sync2_d = sync1_q;
                prev_d  = sync2_q;
            end
        endcase

        edge_det = (warm_q == 2'd2) && (sync2_q != prev_q);
        in_tol   = (32'(cnt_q) >= LO) && (32'(cnt_q) <= HI);
        good_inc = (good_q == LOCK_C) ? LOCK_C : good_q + GW'(1);

        // An edge takes priority over the counter hitting TIMEOUT.
        if (edge_det) begin
            cnt_d     = CW'(1);
            timeout_d = 1'b0;
            if (state_q == WAIT_EDGE) begin
                state_d  = MEASURE;
                good_d   = '0;
                locked_d = 1'b0;
            end else begin
                meas_valid_d = 1'b1;
                half_len_d   = cnt_q;
                level_d      = prev_q;
                if (in_tol) begin
                    good_d = good_inc;
                    if (good_inc == LOCK_C) begin
                        state_d  = LOCK;
                        locked_d = 1'b1;
                    end
                end else begin
                    good_d   = '0;
                    locked_d = 1'b0;
                    state_d  = MEASURE;
                end
            end
        end else if (cnt_q == TO_C) begin
            timeout_d = 1'b1;
            locked_d  = 1'b0;
            good_d    = '0;
            state_d   = WAIT_EDGE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= WAIT_EDGE;
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            prev_q       <= 1'b0;
            warm_q       <= 2'd0;
            cnt_q        <= '0;
            half_len_q   <= '0;
            level_q      <= 1'b0;
            meas_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            timeout_q    <= 1'b0;
            good_q       <= '0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            prev_q       <= prev_d;
            warm_q       <= warm_d;
            cnt_q        <= cnt_d;
            half_len_q   <= half_len_d;
            level_q      <= level_d;
            meas_valid_q <= meas_valid_d;
            locked_q     <= locked_d;
            timeout_q    <= timeout_d;
            good_q       <= good_d;
        end
    end

    assign half_len   = half_len_q;
    assign level      = level_q;
    assign meas_valid = meas_valid_q;
    assign locked     = locked_q;
    assign timeout    = timeout_q;

endmodule
